// File: rtl/mosquito_pkg.sv
// Shared types and constants for the mosquito swarm: FSM states, coordinate width, LFSR seed/taps.
package mosquito_pkg;

  typedef enum logic {FLYING = 1'b0, RESPAWN_WAIT = 1'b1} mosq_state_t;

  localparam int          COORD_W      = 10;
  localparam int          SCREEN_H_DEF = 480;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int s);
    logic [31:0] t;
    t = {v, v};
    return t[(31 - s) -: 16];
  endfunction

endpackage

// File: rtl/mosquito_unit.sv
// One mosquito: FLYING/RESPAWN_WAIT FSM, zig-zag position, direction and respawn countdown.
module mosquito_unit
  import mosquito_pkg::*;
#(
  parameter int SPAWN_X       = 16,
  parameter bit DIR_INIT      = 1'b0,
  parameter int STEP_Y        = 2,
  parameter int STEP_X        = 1,
  parameter int X_MIN         = 16,
  parameter int X_MAX         = 608,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int RESPAWN_TICKS = 64
) (
  input  logic               clk25,
  input  logic               reset_mosquito,
  input  logic               tick,
  input  logic               hit,
  input  logic [COORD_W-1:0] respawn_x,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               alive,
  output logic               escape,
  output logic               kill
);

  typedef logic [COORD_W:0] ext_t;

  mosq_state_t state;
  logic        dir;
  logic [7:0]  cnt;
  ext_t        y_step;
  ext_t        x_right;
  logic signed [COORD_W:0] x_left;

  assign y_step  = {1'b0, y} + ext_t'(STEP_Y);
  assign x_right = {1'b0, x} + ext_t'(STEP_X);
  assign x_left  = $signed({1'b0, x}) - $signed(ext_t'(STEP_X));
  assign kill    = hit && (state == FLYING);
  // A hit on the same cycle takes priority and suppresses the escape
  assign escape  = (state == FLYING) && tick && !hit && (y_step >= ext_t'(SCREEN_H));

  always_ff @(posedge clk25 or posedge reset_mosquito) begin
    if (reset_mosquito) begin
      state <= FLYING;
      alive <= 1'b1;
      x     <= COORD_W'(SPAWN_X);
      y     <= '0;
      dir   <= DIR_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        FLYING: begin
          if (hit) begin
            state <= RESPAWN_WAIT;
            alive <= 1'b0;
            cnt   <= 8'(RESPAWN_TICKS);
          end else if (tick) begin
            if (escape) begin
              y     <= COORD_W'(SCREEN_H - 1);
              state <= RESPAWN_WAIT;
              alive <= 1'b0;
              cnt   <= 8'(RESPAWN_TICKS);
            end else begin
              y <= y_step[COORD_W-1:0];
            end
            if (!dir) begin
              if (x_right >= ext_t'(X_MAX)) begin
                x   <= COORD_W'(X_MAX);
                dir <= 1'b1;
              end else begin
                x <= x_right[COORD_W-1:0];
              end
            end else begin
              if (x_left <= $signed(ext_t'(X_MIN))) begin
                x   <= COORD_W'(X_MIN);
                dir <= 1'b0;
              end else begin
                x <= x_left[COORD_W-1:0];
              end
            end
          end
        end
        RESPAWN_WAIT: begin
          if (tick) begin
            if (cnt == 8'd1) begin
              state <= FLYING;
              alive <= 1'b1;
              y     <= '0;
              x     <= respawn_x;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mosquito_swarm_controller.sv
// NUM_MOSQ-mosquito controller: motion prescaler, per-mosquito units, kill counter, escape pulse.
// Optional MOSQ_LFSR_SPAWN_EN: respawn x from a 16-bit LFSR instead of the fixed reset column.
module mosquito_swarm_controller
  import mosquito_pkg::*;
#(
  parameter int NUM_MOSQ      = 4,
  parameter int TICK_DIV      = 32768,
  parameter int STEP_Y        = 2,
  parameter int STEP_X        = 1,
  parameter int X_MIN         = 16,
  parameter int X_MAX         = 608,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int RESPAWN_TICKS = 64
) (
  input  logic                          clk25,
  input  logic                          reset_mosquito,
  input  logic                          run,
  input  logic [NUM_MOSQ-1:0]           hit_mask,
  output logic [COORD_W*NUM_MOSQ-1:0]   mosq_x,
  output logic [COORD_W*NUM_MOSQ-1:0]   mosq_y,
  output logic [NUM_MOSQ-1:0]           mosq_alive,
  output logic                          escape_pulse,
  output logic [7:0]                    kill_count
);

  localparam int PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SPACING = (X_MAX - X_MIN) / NUM_MOSQ;

  logic [PRE_W-1:0]    pre;
  logic                tick;
  logic [NUM_MOSQ-1:0] escapes;
  logic [NUM_MOSQ-1:0] kills;
  logic [3:0]          n_kill;
  logic [8:0]          kill_sum;

  assign tick = run && (pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk25 or posedge reset_mosquito) begin
    if (reset_mosquito) pre <= '0;
    else if (run)       pre <= tick ? '0 : pre + 1'b1;
  end

`ifdef MOSQ_LFSR_SPAWN_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk25 or posedge reset_mosquito) begin
    if (reset_mosquito) lfsr <= LFSR_SEED;
    else if (tick)      lfsr <= lfsr_next(lfsr);
  end
`endif

  for (genvar g = 0; g < NUM_MOSQ; g++) begin : g_mosq
    logic [COORD_W-1:0] respawn_x;
`ifdef MOSQ_LFSR_SPAWN_EN
    // Rotation keeps simultaneous respawns from landing on the same column
    assign respawn_x = COORD_W'(X_MIN) + COORD_W'(rotl16(lfsr, (3 * g) % 16) & 16'h01FF);
`else
    assign respawn_x = COORD_W'(X_MIN + g * SPACING);
`endif

    mosquito_unit #(
      .SPAWN_X       (X_MIN + g * SPACING),
      .DIR_INIT      (g % 2 == 1),
      .STEP_Y        (STEP_Y),
      .STEP_X        (STEP_X),
      .X_MIN         (X_MIN),
      .X_MAX         (X_MAX),
      .SCREEN_H      (SCREEN_H),
      .RESPAWN_TICKS (RESPAWN_TICKS)
    ) u_unit (
      .clk25          (clk25),
      .reset_mosquito (reset_mosquito),
      .tick           (tick),
      .hit            (hit_mask[g]),
      .respawn_x      (respawn_x),
      .x              (mosq_x[COORD_W*g +: COORD_W]),
      .y              (mosq_y[COORD_W*g +: COORD_W]),
      .alive          (mosq_alive[g]),
      .escape         (escapes[g]),
      .kill           (kills[g])
    );
  end

  always_comb begin
    n_kill = '0;
    for (int i = 0; i < NUM_MOSQ; i++) n_kill = n_kill + 4'(kills[i]);
    kill_sum = 9'(kill_count) + 9'(n_kill);
  end

  always_ff @(posedge clk25 or posedge reset_mosquito) begin
    if (reset_mosquito) begin
      escape_pulse <= 1'b0;
      kill_count   <= '0;
    end else begin
      escape_pulse <= |escapes;
      kill_count   <= (kill_sum > 9'd255) ? 8'd255 : kill_sum[7:0];
    end
  end

endmodule
